// File: rtl/miriscv_mdu_iter_if.sv
// Request/result bundle between the execute stage and the iterative MDU.
//   mdu_req       operation request, held with stable operands/op until stall is low
//   mdu_port_a    operand A (rs1)
//   mdu_port_b    operand B (rs2)
//   mdu_op        RISC-V funct3 of the M-extension op
//   mdu_kill      abort the current multicycle operation
//   mdu_keep      hold the completed result while the pipeline is stalled elsewhere
//   mdu_result    result, valid when mdu_req=1 and mdu_stall_req=0
//   mdu_stall_req stall request while computing
// master: pipeline side, slave: MDU side.
interface miriscv_mdu_iter_if #(
  parameter int unsigned XLEN = 32
);
  logic            mdu_req;
  logic [XLEN-1:0] mdu_port_a;
  logic [XLEN-1:0] mdu_port_b;
  logic [2:0]      mdu_op;
  logic            mdu_kill;
  logic            mdu_keep;
  logic [XLEN-1:0] mdu_result;
  logic            mdu_stall_req;

  modport master (
    output mdu_req, mdu_port_a, mdu_port_b, mdu_op, mdu_kill, mdu_keep,
    input  mdu_result, mdu_stall_req
  );

  modport slave (
    input  mdu_req, mdu_port_a, mdu_port_b, mdu_op, mdu_kill, mdu_keep,
    output mdu_result, mdu_stall_req
  );
endinterface

// File: rtl/miriscv_mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide unit with divide-by-zero / overflow fast paths and a
// one-entry result cache so fused pairs (MULH->MUL, DIV->REM) skip recomputation.
//   clk_i    clock, rising edge
//   arstn_i  asynchronous active-low reset
//   mdu      slave side of miriscv_mdu_iter_if (req/operands/op/kill/keep in, result/stall out)
module miriscv_mdu_iter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_UNROLL = 1,
  parameter int unsigned CACHE_EN   = 1
) (
  input logic               clk_i,
  input logic               arstn_i,
  miriscv_mdu_iter_if.slave mdu
);

  localparam int unsigned MulSteps = XLEN / MUL_UNROLL;
  localparam int unsigned CntW     = $clog2(XLEN);
  localparam int unsigned PpW      = XLEN + MUL_UNROLL;

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   raw_a_q, raw_b_q;
  logic [XLEN-1:0]   opa_q, opb_q;   // |a| (dividend/quotient in DIV), |b| (shifting multiplier)
  logic [2*XLEN-1:0] acc_q;          // product; upper half is the remainder in DIV
  logic              sign_a_q, sign_b_q;
  logic [XLEN-1:0]   result_q;
  logic              c_valid_q, c_div_q;
  logic [2:0]        c_op_q;
  logic [XLEN-1:0]   c_a_q, c_b_q, c_lo_q, c_hi_q;

  logic [2:0]      op;
  logic [XLEN-1:0] a, b;
  assign op = mdu.mdu_op;
  assign a  = mdu.mdu_port_a;
  assign b  = mdu.mdu_port_b;

  // Operand signedness: MULH/MULHSU/DIV/REM treat a as signed, MULH/DIV/REM treat b as signed.
  logic            is_div, neg_a, neg_b, ovf, hit, fast;
  logic [XLEN-1:0] abs_a, abs_b, fast_res;

  assign is_div = op[2];
  assign neg_a  = a[XLEN-1] & ((op == 3'd1) | (op == 3'd2) | (is_div & ~op[0]));
  assign neg_b  = b[XLEN-1] & ((op == 3'd1) | (is_div & ~op[0]));
  assign abs_a  = neg_a ? -a : a;
  assign abs_b  = neg_b ? -b : b;
  assign ovf    = is_div & ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);

  // MUL reuses any mul entry (low half is sign-independent); MULH* need the same op;
  // DIV/REM pairs share an entry when signedness matches.
  assign hit = (CACHE_EN != 0) && c_valid_q && (a == c_a_q) && (b == c_b_q) &&
               (is_div ? (c_div_q && (op[0] == c_op_q[0]))
                       : (!c_div_q && ((op == 3'd0) || (op == c_op_q))));

  always_comb begin
    fast     = 1'b1;
    fast_res = '0;
    if (is_div && (b == '0)) begin
      fast_res = op[1] ? a : '1;
    end else if (ovf) begin
      fast_res = op[1] ? '0 : a;
    end else if (hit) begin
      fast_res = ((op == 3'd0) || (is_div && !op[1])) ? c_lo_q : c_hi_q;
    end else begin
      fast = 1'b0;
    end
  end

  // Multiply step: add |a| times the next MUL_UNROLL multiplier bits, then shift right.
  logic [PpW-1:0]    pp, mul_sum;
  logic [2*XLEN-1:0] mul_next;
  always_comb begin
    pp = '0;
    for (int unsigned j = 0; j < MUL_UNROLL; j++) begin
      if (opb_q[j]) pp = pp + (PpW'(opa_q) << j);
    end
  end
  assign mul_sum  = PpW'(acc_q[2*XLEN-1:XLEN]) + pp;
  assign mul_next = {mul_sum, acc_q[XLEN-1:MUL_UNROLL]};

  // Restoring divide step: shift in the next dividend bit and subtract if it fits.
  logic [XLEN:0]   div_trial;
  logic            div_ge;
  logic [XLEN-1:0] rem_next;
  assign div_trial = {acc_q[2*XLEN-1:XLEN], opa_q[XLEN-1]} - {1'b0, opb_q};
  assign div_ge    = ~div_trial[XLEN];
  assign rem_next  = div_ge ? div_trial[XLEN-1:0] : {acc_q[2*XLEN-2:XLEN], opa_q[XLEN-1]};

  // Sign fix-up of the finished magnitude result.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, fix_lo, fix_hi, fix_res;
  assign prod    = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
  assign quot    = (sign_a_q ^ sign_b_q) ? -opa_q : opa_q;
  assign rem     = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  assign fix_lo  = op_q[2] ? quot : prod[XLEN-1:0];
  assign fix_hi  = op_q[2] ? rem : prod[2*XLEN-1:XLEN];
  assign fix_res = ((op_q == 3'd0) || (op_q[2] && !op_q[1])) ? fix_lo : fix_hi;

  logic busy;
  assign busy = (state_q == StMul) || (state_q == StDiv) || (state_q == StFix);

  // Reset gates the stall so an in-flight request never stalls while reset is held.
  assign mdu.mdu_stall_req = arstn_i &&
                             (((state_q == StIdle) && mdu.mdu_req && !fast) ||
                              (busy && !mdu.mdu_kill));
  assign mdu.mdu_result    = ((state_q == StIdle) && mdu.mdu_req && fast) ? fast_res : result_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= '0;
      raw_a_q   <= '0;
      raw_b_q   <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      result_q  <= '0;
      c_valid_q <= 1'b0;
      c_div_q   <= 1'b0;
      c_op_q    <= '0;
      c_a_q     <= '0;
      c_b_q     <= '0;
      c_lo_q    <= '0;
      c_hi_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mdu.mdu_req && !fast) begin
            op_q     <= op;
            raw_a_q  <= a;
            raw_b_q  <= b;
            opa_q    <= abs_a;
            opb_q    <= abs_b;
            sign_a_q <= neg_a;
            sign_b_q <= neg_b;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= is_div ? StDiv : StMul;
          end
        end
        StMul: begin
          if (mdu.mdu_kill) begin
            state_q   <= StIdle;
            c_valid_q <= 1'b0;
          end else begin
            acc_q <= mul_next;
            opb_q <= opb_q >> MUL_UNROLL;
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(MulSteps - 1)) state_q <= StFix;
          end
        end
        StDiv: begin
          if (mdu.mdu_kill) begin
            state_q   <= StIdle;
            c_valid_q <= 1'b0;
          end else begin
            acc_q <= {rem_next, {XLEN{1'b0}}};
            opa_q <= {opa_q[XLEN-2:0], div_ge};
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(XLEN - 1)) state_q <= StFix;
          end
        end
        StFix: begin
          if (mdu.mdu_kill) begin
            state_q   <= StIdle;
            c_valid_q <= 1'b0;
          end else begin
            result_q <= fix_res;
            if (CACHE_EN != 0) begin
              c_valid_q <= 1'b1;
              c_div_q   <= op_q[2];
              c_op_q    <= op_q;
              c_a_q     <= raw_a_q;
              c_b_q     <= raw_b_q;
              c_lo_q    <= fix_lo;
              c_hi_q    <= fix_hi;
            end
            state_q <= StDone;
          end
        end
        StDone: begin
          if (mdu.mdu_kill || !mdu.mdu_keep) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_mdu_iter.sv
module tb_miriscv_mdu_iter;
  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic arstn;
  always #5 clk = ~clk;

  miriscv_mdu_iter_if #(.XLEN(XLEN)) mdu_bus ();

  miriscv_mdu_iter #(
    .XLEN      (XLEN),
    .MUL_UNROLL(4),
    .CACHE_EN  (1)
  ) dut (
    .clk_i  (clk),
    .arstn_i(arstn),
    .mdu    (mdu_bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference cache model: last completed computed (non-fast, non-hit) operation.
  bit          m_valid = 1'b0;
  bit          m_div;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b;

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      p;
    logic [63:0] u;
    int          sa, sb, r;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin u = {32'b0, a} * {32'b0, b}; return u[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); u = p; return u[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b}); u = p; return u[63:32]; end
      3'd3: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        r = sa / sb;
        return r;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        r = sa % sb;
        return r;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit model_fast(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return (op[2] && b == 0) ||
           ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic bit model_hit(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (!m_valid || a != m_a || b != m_b) return 1'b0;
    if (op[2]) return m_div && (op[0] == m_op[0]);
    if (m_div) return 1'b0;
    return (op == 3'd0) || (op == m_op);
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int keep_cyc);
    logic [31:0] exp_res;
    int          exp_stall, stalls;
    bit          fast, hit;
    exp_res   = ref_result(op, a, b);
    fast      = model_fast(op, a, b);
    hit       = !fast && model_hit(op, a, b);
    exp_stall = (fast || hit) ? 0 : (op[2] ? XLEN + 2 : XLEN / 4 + 2);
    @(posedge clk);
    #1;
    mdu_bus.mdu_op     = op;
    mdu_bus.mdu_port_a = a;
    mdu_bus.mdu_port_b = b;
    mdu_bus.mdu_keep   = (keep_cyc > 0);
    mdu_bus.mdu_req    = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (mdu_bus.mdu_stall_req && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    check($sformatf("op%0d_stalls a=%h b=%h", op, a, b), 64'(stalls), 64'(exp_stall));
    check($sformatf("op%0d_result a=%h b=%h", op, a, b), 64'(mdu_bus.mdu_result),
          64'(exp_res));
    for (int k = 0; k < keep_cyc; k++) begin
      @(negedge clk);
      check("keep_stall", 64'(mdu_bus.mdu_stall_req), 64'(0));
      check("keep_result", 64'(mdu_bus.mdu_result), 64'(exp_res));
    end
    mdu_bus.mdu_keep = 1'b0;
    @(posedge clk);
    #1;
    mdu_bus.mdu_req = 1'b0;
    if (!fast && !hit) begin
      m_valid = 1'b1;
      m_div   = op[2];
      m_op    = op;
      m_a     = a;
      m_b     = b;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          stalls;
    arstn              = 1'b0;
    mdu_bus.mdu_req    = 1'b0;
    mdu_bus.mdu_kill   = 1'b0;
    mdu_bus.mdu_keep   = 1'b0;
    mdu_bus.mdu_op     = '0;
    mdu_bus.mdu_port_a = '0;
    mdu_bus.mdu_port_b = '0;
    @(negedge clk);
    check("reset_stall", 64'(mdu_bus.mdu_stall_req), 64'(0));
    check("reset_result", 64'(mdu_bus.mdu_result), 64'(0));
    @(negedge clk);
    arstn = 1'b1;

    // Directed sequence
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    do_op(3'd0, 32'h8000_0000, 32'h8000_0000, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(3'd5, 32'd5, 32'd0, 0);
    do_op(3'd7, 32'd7, 32'd0, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);

    // Kill a DIVU in its sixth stall cycle
    @(posedge clk);
    #1;
    mdu_bus.mdu_op     = 3'd5;
    mdu_bus.mdu_port_a = 32'd100;
    mdu_bus.mdu_port_b = 32'd7;
    mdu_bus.mdu_req    = 1'b1;
    stalls = 0;
    repeat (5) begin
      @(negedge clk);
      if (mdu_bus.mdu_stall_req) stalls++;
    end
    check("kill_prestalls", 64'(stalls), 64'(5));
    @(posedge clk);
    #1;
    mdu_bus.mdu_kill = 1'b1;
    @(negedge clk);
    check("kill_stall", 64'(mdu_bus.mdu_stall_req), 64'(0));
    @(posedge clk);
    #1;
    mdu_bus.mdu_kill = 1'b0;
    mdu_bus.mdu_req  = 1'b0;
    m_valid = 1'b0;
    do_op(3'd5, 32'd100, 32'd7, 0);

    // Hold the result in DONE with keep
    do_op(3'd3, 32'hFFFF_FFFF, 32'd2, 3);

    // Reset in the middle of a multiply
    @(posedge clk);
    #1;
    mdu_bus.mdu_op     = 3'd1;
    mdu_bus.mdu_port_a = 32'hFFFF_FFFF;
    mdu_bus.mdu_port_b = 32'd2;
    mdu_bus.mdu_req    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    arstn = 1'b0;
    #1;
    check("midreset_stall", 64'(mdu_bus.mdu_stall_req), 64'(0));
    check("midreset_result", 64'(mdu_bus.mdu_result), 64'(0));
    @(negedge clk);
    mdu_bus.mdu_req = 1'b0;
    arstn   = 1'b1;
    m_valid = 1'b0;
    do_op(3'd0, 32'hFFFF_FFFF, 32'd2, 0);

    // Randomized ops, biased towards special operands and operand reuse (cache hits)
    ra = 32'h0;
    rb = 32'h0;
    for (int i = 0; i < 80; i++) begin
      rop = 3'($urandom_range(0, 7));
      if (i == 0 || $urandom_range(0, 3) != 0) begin
        ra = $urandom;
        rb = $urandom;
        case ($urandom_range(0, 7))
          0: rb = 32'h0;
          1: ra = 32'h8000_0000;
          2: rb = 32'hFFFF_FFFF;
          3: rb = $urandom_range(1, 15);
          default: ;
        endcase
      end
      do_op(rop, ra, rb, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
